// File: rtl/fifo_umbral_param_if.sv
// fifo_umbral_param_if: request/flag bundle between a producer/consumer and
// the fifo_umbral_param buffer. The master drives writes, reads and thresholds.
// The slave (the FIFO) returns read data, valid, occupancy, flags and error.
interface fifo_umbral_param_if #(
  parameter int BW  = 6,
  parameter int LEN = 4
);
  logic           fifo_wr;
  logic           fifo_rd;
  logic [BW-1:0]  fifo_data_in;
  logic [LEN-1:0] umbral_bajo;
  logic [LEN-1:0] umbral_alto;
  logic [BW-1:0]  fifo_data_out;
  logic           fifo_valid;
  logic [LEN:0]   fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_almost_full;
  logic           fifo_almost_empty;
  logic           error_output;

  modport master (
    output fifo_wr, fifo_rd, fifo_data_in, umbral_bajo, umbral_alto,
    input  fifo_data_out, fifo_valid, fifo_count, fifo_full, fifo_empty,
           fifo_almost_full, fifo_almost_empty, error_output
  );

  modport slave (
    input  fifo_wr, fifo_rd, fifo_data_in, umbral_bajo, umbral_alto,
    output fifo_data_out, fifo_valid, fifo_count, fifo_full, fifo_empty,
           fifo_almost_full, fifo_almost_empty, error_output
  );
endinterface

// File: rtl/fifo_umbral_param.sv
// fifo_umbral_param: parametrised synchronous FIFO for per-VC buffering.
// It has runtime almost-empty/almost-full thresholds, a registered read with
// valid, and an occupancy count. A write is accepted on a full FIFO when a read
// is accepted in the same cycle.
// Optional macro FIFO_ERR_STICKY_EN: when it is defined, error_output latches
// on overflow/underflow until reset. Otherwise it pulses for one cycle for each
// offending request cycle.
module fifo_umbral_param #(
  parameter int BW  = 6,
  parameter int LEN = 4
) (
  input logic                clk,
  input logic                reset,
  fifo_umbral_param_if.slave bus
);
  localparam int           DEPTH   = 2**LEN;
  localparam logic [LEN:0] DEPTH_C = (LEN+1)'(DEPTH);

  logic [BW-1:0]  mem_q [DEPTH];
  logic [LEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN:0]   count_q, count_d;
  logic [BW-1:0]  dout_q, dout_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;

  logic full, empty;
  logic rd_acc, wr_acc, ovf, udf;

  // The flags are combinational from the registered count, so a threshold change takes effect immediately
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  assign bus.fifo_full         = full;
  assign bus.fifo_empty        = empty;
  assign bus.fifo_almost_full  = (count_q >= {1'b0, bus.umbral_alto});
  assign bus.fifo_almost_empty = (count_q <= {1'b0, bus.umbral_bajo});
  assign bus.fifo_count        = count_q;
  assign bus.fifo_data_out     = dout_q;
  assign bus.fifo_valid        = valid_q;
  assign bus.error_output      = err_q;

  // Request acceptance, error detection and next state for pointers, count and read port
  always_comb begin
    // A read on an empty FIFO is never satisfied by a write in the same cycle (no bypass)
    rd_acc = bus.fifo_rd && !empty;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle
    wr_acc = bus.fifo_wr && (!full || rd_acc);
    ovf    = bus.fifo_wr && full && !rd_acc;
    udf    = bus.fifo_rd && empty;

    wr_ptr_d = wr_acc ? wr_ptr_q + LEN'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + LEN'(1) : rd_ptr_q;

    count_d = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + (LEN+1)'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - (LEN+1)'(1);

    // After an underflow or an idle cycle, the read port holds its last value
    dout_d  = rd_acc ? mem_q[rd_ptr_q] : dout_q;
    valid_d = rd_acc;

`ifdef FIFO_ERR_STICKY_EN
    err_d = err_q || ovf || udf;
`else
    err_d = ovf || udf;
`endif
  end

  // Control registers. Requests made in the reset cycle have no effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Storage is not cleared by reset: stale entries cannot be reached because both pointers return to 0
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem_q[wr_ptr_q] <= bus.fifo_data_in;
  end
endmodule
